arp_recv: RTL and testbench

Receive-side ARP frame decoder: the counterpart of the ARP transmitter in the Ethernet block. Runs in the GMII receive clock domain, strips preamble/SFD, parses Ethernet II + ARP fields, checks the FCS, and presents the fields of each accepted ARP request or reply in the same field layout the transmitter consumes. The result is handed to the NIOS-II side through a crossing FIFO outside this block.

---
 rtl/arp_recv.sv | 243 ++++++++++++++++++++++++
 tb/tb_arp_recv.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_recv.sv
// arp_recv: GMII receive-side ARP frame decoder.
// Strips preamble/SFD, shadows Ethernet II + ARP fields by byte index,
// checks the FCS and publishes accepted ARP requests/replies.
module arp_recv #(
  parameter int unsigned MIN_LEN = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_dv,
  input  logic [47:0] i_my_mac,
  output logic [47:0] o_dst_mac,
  output logic [47:0] o_src_mac,
  output logic [1:0]  o_operation,
  output logic [47:0] o_SHA,
  output logic [47:0] o_THA,
  output logic [31:0] o_SPA,
  output logic [31:0] o_TPA,
  output logic        o_valid,
  output logic        o_err,
  output logic [15:0] o_good_cnt,
  output logic [15:0] o_err_cnt
);

  localparam int unsigned CNT_W       = 7;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(127);
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [7:0]  BYTE_PRE    = 8'h55;
  localparam logic [7:0]  BYTE_SFD    = 8'hD5;

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_HDR, S_DROP} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] crc_q, crc_d;

  logic [47:0] sh_dst_q, sh_dst_d, sh_src_q, sh_src_d;
  logic [15:0] sh_etype_q, sh_etype_d, sh_htype_q, sh_htype_d;
  logic [15:0] sh_ptype_q, sh_ptype_d, sh_oper_q, sh_oper_d;
  logic [7:0]  sh_hlen_q, sh_hlen_d, sh_plen_q, sh_plen_d;
  logic [47:0] sh_sha_q, sh_sha_d, sh_tha_q, sh_tha_d;
  logic [31:0] sh_spa_q, sh_spa_d, sh_tpa_q, sh_tpa_d;

  logic [47:0] dst_mac_q, dst_mac_d, src_mac_q, src_mac_d;
  logic [1:0]  operation_q, operation_d;
  logic [47:0] sha_q, sha_d, tha_q, tha_d;
  logic [31:0] spa_q, spa_d, tpa_q, tpa_d;
  logic        valid_q, valid_d, err_q, err_d;
  logic [15:0] good_cnt_q, good_cnt_d, err_cnt_q, err_cnt_d;

  logic sof_c, hdr_byte_c, eval_c, bad_c, accept_c;

  // One byte of reflected CRC-32, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

  assign sof_c      = (state_q == S_IDLE || state_q == S_PRE) && i_rx_dv && (i_rx_data == BYTE_SFD);
  assign hdr_byte_c = (state_q == S_HDR) && i_rx_dv;
  assign eval_c     = (state_q == S_HDR) && !i_rx_dv;

  assign bad_c    = (32'(cnt_q) < MIN_LEN) || (crc_q != CRC_RESIDUE);
  assign accept_c = (sh_etype_q == 16'h0806) && (sh_htype_q == 16'h0001) &&
                    (sh_ptype_q == 16'h0800) && (sh_hlen_q == 8'd6) && (sh_plen_q == 8'd4) &&
                    ((sh_oper_q == 16'd1) || (sh_oper_q == 16'd2)) &&
                    ((sh_dst_q == 48'hFFFF_FFFF_FFFF) || (sh_dst_q == i_my_mac));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_rx_dv) begin
          if (i_rx_data == BYTE_PRE)      state_d = S_PRE;
          else if (i_rx_data == BYTE_SFD) state_d = S_HDR;
          else                            state_d = S_DROP;
        end
      end
      S_PRE: begin
        if (!i_rx_dv)                   state_d = S_IDLE;
        else if (i_rx_data == BYTE_PRE) state_d = S_PRE;
        else if (i_rx_data == BYTE_SFD) state_d = S_HDR;
        else                            state_d = S_DROP;
      end
      S_HDR:   if (!i_rx_dv) state_d = S_IDLE;
      S_DROP:  if (!i_rx_dv) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Byte counter, CRC and shadow field capture.
  always_comb begin
    cnt_d      = cnt_q;
    crc_d      = crc_q;
    sh_dst_d   = sh_dst_q;
    sh_src_d   = sh_src_q;
    sh_etype_d = sh_etype_q;
    sh_htype_d = sh_htype_q;
    sh_ptype_d = sh_ptype_q;
    sh_hlen_d  = sh_hlen_q;
    sh_plen_d  = sh_plen_q;
    sh_oper_d  = sh_oper_q;
    sh_sha_d   = sh_sha_q;
    sh_spa_d   = sh_spa_q;
    sh_tha_d   = sh_tha_q;
    sh_tpa_d   = sh_tpa_q;
    if (sof_c) begin
      cnt_d = '0;
      crc_d = '1;
    end else if (hdr_byte_c) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      crc_d = crc_byte(crc_q, i_rx_data);
      // Fields arrive MSB first, so each one is a left shift register.
      if      (cnt_q < CNT_W'(6))  sh_dst_d   = {sh_dst_q[39:0], i_rx_data};
      else if (cnt_q < CNT_W'(12)) sh_src_d   = {sh_src_q[39:0], i_rx_data};
      else if (cnt_q < CNT_W'(14)) sh_etype_d = {sh_etype_q[7:0], i_rx_data};
      else if (cnt_q < CNT_W'(16)) sh_htype_d = {sh_htype_q[7:0], i_rx_data};
      else if (cnt_q < CNT_W'(18)) sh_ptype_d = {sh_ptype_q[7:0], i_rx_data};
      else if (cnt_q < CNT_W'(19)) sh_hlen_d  = i_rx_data;
      else if (cnt_q < CNT_W'(20)) sh_plen_d  = i_rx_data;
      else if (cnt_q < CNT_W'(22)) sh_oper_d  = {sh_oper_q[7:0], i_rx_data};
      else if (cnt_q < CNT_W'(28)) sh_sha_d   = {sh_sha_q[39:0], i_rx_data};
      else if (cnt_q < CNT_W'(32)) sh_spa_d   = {sh_spa_q[23:0], i_rx_data};
      else if (cnt_q < CNT_W'(38)) sh_tha_d   = {sh_tha_q[39:0], i_rx_data};
      else if (cnt_q < CNT_W'(42)) sh_tpa_d   = {sh_tpa_q[23:0], i_rx_data};
    end
  end

  // Frame evaluation: pulses, published fields and event counters.
  always_comb begin
    valid_d     = 1'b0;
    err_d       = 1'b0;
    dst_mac_d   = dst_mac_q;
    src_mac_d   = src_mac_q;
    operation_d = operation_q;
    sha_d       = sha_q;
    tha_d       = tha_q;
    spa_d       = spa_q;
    tpa_d       = tpa_q;
    good_cnt_d  = good_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (eval_c) begin
      if (bad_c) begin
        err_d     = 1'b1;
        err_cnt_d = err_cnt_q + 16'd1;
      end else if (accept_c) begin
        valid_d     = 1'b1;
        good_cnt_d  = good_cnt_q + 16'd1;
        dst_mac_d   = sh_dst_q;
        src_mac_d   = sh_src_q;
        operation_d = sh_oper_q[1:0];
        sha_d       = sh_sha_q;
        tha_d       = sh_tha_q;
        spa_d       = sh_spa_q;
        tpa_d       = sh_tpa_q;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      crc_q       <= '0;
      sh_dst_q    <= '0;
      sh_src_q    <= '0;
      sh_etype_q  <= '0;
      sh_htype_q  <= '0;
      sh_ptype_q  <= '0;
      sh_hlen_q   <= '0;
      sh_plen_q   <= '0;
      sh_oper_q   <= '0;
      sh_sha_q    <= '0;
      sh_spa_q    <= '0;
      sh_tha_q    <= '0;
      sh_tpa_q    <= '0;
      dst_mac_q   <= '0;
      src_mac_q   <= '0;
      operation_q <= '0;
      sha_q       <= '0;
      tha_q       <= '0;
      spa_q       <= '0;
      tpa_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      good_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      sh_dst_q    <= sh_dst_d;
      sh_src_q    <= sh_src_d;
      sh_etype_q  <= sh_etype_d;
      sh_htype_q  <= sh_htype_d;
      sh_ptype_q  <= sh_ptype_d;
      sh_hlen_q   <= sh_hlen_d;
      sh_plen_q   <= sh_plen_d;
      sh_oper_q   <= sh_oper_d;
      sh_sha_q    <= sh_sha_d;
      sh_spa_q    <= sh_spa_d;
      sh_tha_q    <= sh_tha_d;
      sh_tpa_q    <= sh_tpa_d;
      dst_mac_q   <= dst_mac_d;
      src_mac_q   <= src_mac_d;
      operation_q <= operation_d;
      sha_q       <= sha_d;
      tha_q       <= tha_d;
      spa_q       <= spa_d;
      tpa_q       <= tpa_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      good_cnt_q  <= good_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_dst_mac   = dst_mac_q;
  assign o_src_mac   = src_mac_q;
  assign o_operation = operation_q;
  assign o_SHA       = sha_q;
  assign o_THA       = tha_q;
  assign o_SPA       = spa_q;
  assign o_TPA       = tpa_q;
  assign o_valid     = valid_q;
  assign o_err       = err_q;
  assign o_good_cnt  = good_cnt_q;
  assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_arp_recv.sv
// tb_arp_recv: directed frame table plus hand sequences for arp_recv.
module tb_arp_recv;

  localparam logic [47:0] BC  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MY  = 48'h0200_0000_00AA;
  localparam logic [47:0] OT  = 48'h0200_0000_00BB;
  localparam logic [47:0] SRC = 48'h0200_0000_0001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_dv = 1'b0;
  logic [47:0] o_dst_mac, o_src_mac, o_SHA, o_THA;
  logic [1:0]  o_operation;
  logic [31:0] o_SPA, o_TPA;
  logic        o_valid, o_err;
  logic [15:0] o_good_cnt, o_err_cnt;

  arp_recv #(.MIN_LEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .i_rx_data(i_rx_data), .i_rx_dv(i_rx_dv), .i_my_mac(MY),
    .o_dst_mac(o_dst_mac), .o_src_mac(o_src_mac), .o_operation(o_operation),
    .o_SHA(o_SHA), .o_THA(o_THA), .o_SPA(o_SPA), .o_TPA(o_TPA),
    .o_valid(o_valid), .o_err(o_err), .o_good_cnt(o_good_cnt), .o_err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  // Running pulse tallies; tests compare deltas around each frame.
  int vpulse = 0;
  int epulse = 0;
  always @(negedge clk) begin
    if (o_valid) vpulse <= vpulse + 1;
    if (o_err)   epulse <= epulse + 1;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0] frm [0:199];
  int flen;

  typedef struct {
    logic [47:0] dst;
    logic [15:0] etype;
    logic [15:0] oper;
    logic [31:0] spa;
    logic [31:0] tpa;
    int          plen;
    logic        flip;
    logic        exp_valid;
    logic        exp_err;
    logic [1:0]  exp_oper;
    logic [47:0] exp_dst;
    logic [31:0] exp_spa;
    logic [31:0] exp_tpa;
    logic [15:0] exp_good;
    logic [15:0] exp_errc;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int b = 0; b < 8; b++) c = (c[0] ^ d[b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Builds an ARP-layout frame of plen bytes followed by its FCS.
  task automatic build(input logic [47:0] dst, input logic [15:0] etype, input logic [15:0] oper,
                       input logic [31:0] spa, input logic [31:0] tpa, input int plen, input logic flip);
    logic [31:0] c;
    logic [31:0] fcs;
    for (int i = 0; i < 200; i++) frm[i] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      frm[i]      = dst[47-8*i -: 8];
      frm[6+i]    = SRC[47-8*i -: 8];
      frm[22+i]   = SRC[47-8*i -: 8];
    end
    frm[12] = etype[15:8]; frm[13] = etype[7:0];
    frm[14] = 8'h00;       frm[15] = 8'h01;
    frm[16] = 8'h08;       frm[17] = 8'h00;
    frm[18] = 8'h06;       frm[19] = 8'h04;
    frm[20] = oper[15:8];  frm[21] = oper[7:0];
    for (int i = 0; i < 4; i++) begin
      frm[28+i] = spa[31-8*i -: 8];
      frm[38+i] = tpa[31-8*i -: 8];
    end
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < plen; i++) c = crc_upd(c, frm[i]);
    fcs = ~c;
    for (int k = 0; k < 4; k++) frm[plen+k] = fcs[8*k +: 8];
    if (flip) frm[plen][0] = ~frm[plen][0];
    flen = plen + 4;
  endtask

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    i_rx_dv = 1'b1;
    i_rx_data = b;
  endtask

  task automatic end_frame();
    @(negedge clk);
    i_rx_dv = 1'b0;
    i_rx_data = 8'h00;
  endtask

  task automatic send_pre();
    for (int i = 0; i < 7; i++) drive(8'h55);
    drive(8'hD5);
  endtask

  task automatic send_body();
    send_pre();
    for (int i = 0; i < flen; i++) drive(frm[i]);
  endtask

  initial begin
    int v0, e0;
    vecs[0] = '{BC, 16'h0806, 16'd1, 32'hC0A80001, 32'hC0A80002, 60, 1'b0, 1'b1, 1'b0, 2'b01, BC, 32'hC0A80001, 32'hC0A80002, 16'd1, 16'd0};
    vecs[1] = '{BC, 16'h0806, 16'd1, 32'hC0A80001, 32'hC0A80002, 60, 1'b1, 1'b0, 1'b1, 2'b01, BC, 32'hC0A80001, 32'hC0A80002, 16'd1, 16'd1};
    vecs[2] = '{BC, 16'h0800, 16'd1, 32'hC0A80003, 32'hC0A80004, 60, 1'b0, 1'b0, 1'b0, 2'b01, BC, 32'hC0A80001, 32'hC0A80002, 16'd1, 16'd1};
    vecs[3] = '{BC, 16'h0806, 16'd3, 32'hC0A80003, 32'hC0A80004, 60, 1'b0, 1'b0, 1'b0, 2'b01, BC, 32'hC0A80001, 32'hC0A80002, 16'd1, 16'd1};
    vecs[4] = '{MY, 16'h0806, 16'd2, 32'hC0A80005, 32'hC0A80006, 60, 1'b0, 1'b1, 1'b0, 2'b10, MY, 32'hC0A80005, 32'hC0A80006, 16'd2, 16'd1};
    vecs[5] = '{OT, 16'h0806, 16'd2, 32'hC0A80007, 32'hC0A80008, 60, 1'b0, 1'b0, 1'b0, 2'b10, MY, 32'hC0A80005, 32'hC0A80006, 16'd2, 16'd1};
    vecs[6] = '{BC, 16'h0806, 16'd1, 32'hC0A80009, 32'hC0A8000A, 36, 1'b0, 1'b0, 1'b1, 2'b10, MY, 32'hC0A80005, 32'hC0A80006, 16'd2, 16'd2};
    vecs[7] = '{BC, 16'h0806, 16'd1, 32'hC0A80011, 32'hC0A80012, 59, 1'b0, 1'b0, 1'b1, 2'b10, MY, 32'hC0A80005, 32'hC0A80006, 16'd2, 16'd3};
    vecs[8] = '{BC, 16'h0806, 16'd1, 32'hC0A80013, 32'hC0A80014, 130, 1'b0, 1'b1, 1'b0, 2'b01, BC, 32'hC0A80013, 32'hC0A80014, 16'd3, 16'd3};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    chk("rst_good_cnt", 64'(o_good_cnt), 64'd0);
    chk("rst_err_cnt", 64'(o_err_cnt), 64'd0);
    chk("rst_dst", 64'(o_dst_mac), 64'd0);
    chk("rst_spa", 64'(o_SPA), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      v0 = vpulse;
      e0 = epulse;
      build(vecs[i].dst, vecs[i].etype, vecs[i].oper, vecs[i].spa, vecs[i].tpa, vecs[i].plen, vecs[i].flip);
      send_body();
      end_frame();
      @(negedge clk);
      chk($sformatf("v%0d_valid_edge", i), 64'(o_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("v%0d_err_edge", i), 64'(o_err), 64'(vecs[i].exp_err));
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_valid_pulses", i), 64'(vpulse - v0), 64'(vecs[i].exp_valid));
      chk($sformatf("v%0d_err_pulses", i), 64'(epulse - e0), 64'(vecs[i].exp_err));
      chk($sformatf("v%0d_oper", i), 64'(o_operation), 64'(vecs[i].exp_oper));
      chk($sformatf("v%0d_dst", i), 64'(o_dst_mac), 64'(vecs[i].exp_dst));
      chk($sformatf("v%0d_spa", i), 64'(o_SPA), 64'(vecs[i].exp_spa));
      chk($sformatf("v%0d_tpa", i), 64'(o_TPA), 64'(vecs[i].exp_tpa));
      chk($sformatf("v%0d_good_cnt", i), 64'(o_good_cnt), 64'(vecs[i].exp_good));
      chk($sformatf("v%0d_err_cnt", i), 64'(o_err_cnt), 64'(vecs[i].exp_errc));
      if (o_good_cnt != 16'd0) begin
        chk($sformatf("v%0d_src", i), 64'(o_src_mac), 64'(SRC));
        chk($sformatf("v%0d_sha", i), 64'(o_SHA), 64'(SRC));
        chk($sformatf("v%0d_tha", i), 64'(o_THA), 64'd0);
      end
    end

    // Junk first byte, then a complete valid frame without dv dropping.
    v0 = vpulse; e0 = epulse;
    build(BC, 16'h0806, 16'd1, 32'hC0A80015, 32'hC0A80016, 60, 1'b0);
    drive(8'h12);
    send_body();
    end_frame();
    repeat (4) @(negedge clk);
    chk("junk_pulses", 64'((vpulse - v0) + (epulse - e0)), 64'd0);
    chk("junk_good_cnt", 64'(o_good_cnt), 64'd3);
    chk("junk_err_cnt", 64'(o_err_cnt), 64'd3);

    // dv drops inside the preamble.
    v0 = vpulse; e0 = epulse;
    for (int i = 0; i < 7; i++) drive(8'h55);
    end_frame();
    repeat (4) @(negedge clk);
    chk("pre_drop_pulses", 64'((vpulse - v0) + (epulse - e0)), 64'd0);

    // Two valid frames separated by a single idle cycle.
    v0 = vpulse; e0 = epulse;
    build(BC, 16'h0806, 16'd1, 32'hC0A80021, 32'hC0A80022, 60, 1'b0);
    send_body();
    end_frame();
    build(MY, 16'h0806, 16'd2, 32'hC0A80023, 32'hC0A80024, 60, 1'b0);
    send_body();
    end_frame();
    repeat (4) @(negedge clk);
    chk("gap1_valid_pulses", 64'(vpulse - v0), 64'd2);
    chk("gap1_err_pulses", 64'(epulse - e0), 64'd0);
    chk("gap1_good_cnt", 64'(o_good_cnt), 64'd5);
    chk("gap1_spa", 64'(o_SPA), 64'hC0A80023);
    chk("gap1_oper", 64'(o_operation), 64'd2);

    // Reset asserted mid-header, released while the frame is still running.
    v0 = vpulse; e0 = epulse;
    build(BC, 16'h0806, 16'd1, 32'hC0A80031, 32'hC0A80032, 60, 1'b0);
    send_pre();
    for (int i = 0; i < 21; i++) drive(frm[i]);
    @(negedge clk);
    rst_n = 1'b0;
    i_rx_data = frm[21];
    #1;
    chk("midrst_good_cnt", 64'(o_good_cnt), 64'd0);
    chk("midrst_err_cnt", 64'(o_err_cnt), 64'd0);
    chk("midrst_dst", 64'(o_dst_mac), 64'd0);
    chk("midrst_spa", 64'(o_SPA), 64'd0);
    chk("midrst_oper", 64'(o_operation), 64'd0);
    chk("midrst_valid", 64'(o_valid), 64'd0);
    for (int i = 22; i < 25; i++) drive(frm[i]);
    @(negedge clk);
    rst_n = 1'b1;
    i_rx_data = frm[25];
    for (int i = 26; i < flen; i++) drive(frm[i]);
    end_frame();
    repeat (4) @(negedge clk);
    chk("postrst_pulses", 64'((vpulse - v0) + (epulse - e0)), 64'd0);
    chk("postrst_good_cnt", 64'(o_good_cnt), 64'd0);

    build(BC, 16'h0806, 16'd1, 32'hC0A80041, 32'hC0A80042, 60, 1'b0);
    send_body();
    end_frame();
    repeat (4) @(negedge clk);
    chk("after_rst_good_cnt", 64'(o_good_cnt), 64'd1);
    chk("after_rst_err_cnt", 64'(o_err_cnt), 64'd0);
    chk("after_rst_spa", 64'(o_SPA), 64'hC0A80041);
    chk("after_rst_valid_pulses", 64'(vpulse - v0), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
